// File: rtl/press_classifier_if.sv
// Button-gesture bus: the debounced level in, the gesture pulses and counter out.
interface press_classifier_if;
    logic       sen;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       repeat_pulse;
    logic       pressed;
    logic [7:0] event_count;

    modport master (
        output sen,
        input  short_press,
        input  long_press,
        input  double_press,
        input  repeat_pulse,
        input  pressed,
        input  event_count
    );

    modport slave (
        input  sen,
        output short_press,
        output long_press,
        output double_press,
        output repeat_pulse,
        output pressed,
        output event_count
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, long and double presses,
// with auto-repeat while a long press is held and a wrapping event counter.
module press_classifier #(
    parameter int CNT_W        = 26,
    parameter int LONG_TICKS   = 50000000,
    parameter int GAP_TICKS    = 12500000,
    parameter int REPEAT_TICKS = 10000000
) (
    input  logic              clk,
    input  logic              reset,
    press_classifier_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_TICKS - 1);
    localparam bit               REPEAT_EN   = (REPEAT_TICKS != 0);
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_TICKS - 1) : CNT_ZERO;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sen_q, sen_d;
    logic             pressed_q, pressed_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             repeat_q, repeat_d;
    logic [7:0]       event_count_q, event_count_d;
    logic             rise_s;

    // sen_q resets high so a button held through reset must be released before it counts.
    assign rise_s = bus.sen & ~sen_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sen_d     = bus.sen;
        pressed_d = bus.sen;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = PRESS1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS1: begin
                if (!bus.sen) begin
                    state_d = GAP;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                // A second press wins over the timeout when both land on the same edge.
                if (bus.sen) begin
                    state_d = PRESS2;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!bus.sen) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = PRESS2;
                end
            end
            HOLD: begin
                if (!bus.sen) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    cnt_d    = CNT_ZERO;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (short_d | long_d | double_d) begin
            event_count_d = event_count_q + 8'd1;
        end else begin
            event_count_d = event_count_q;
        end
    end

    // State, counters and registered outputs; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            sen_q         <= 1'b1;
            pressed_q     <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            double_q      <= 1'b0;
            repeat_q      <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sen_q         <= sen_d;
            pressed_q     <= pressed_d;
            short_q       <= short_d;
            long_q        <= long_d;
            double_q      <= double_d;
            repeat_q      <= repeat_d;
            event_count_q <= event_count_d;
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = double_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.pressed      = pressed_q;
    assign bus.event_count  = event_count_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: gesture table, hand-written reset/gap/wrap sequences,
// and a random waveform checked against a run-length gesture model.
module tb_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 4;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic reset;

    press_classifier_if bus();

    press_classifier #(
        .CNT_W        (8),
        .LONG_TICKS   (LONG),
        .GAP_TICKS    (GAP),
        .REPEAT_TICKS (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    typedef struct {
        string name;
        int    h1;
        int    l1;
        int    h2;
        int    kind;       // 0 short, 1 long, 2 double
        int    ev_edge;    // edge offset from the first high sample
        int    n_rep;
        int    rep_first;  // -1 when no repeat expected
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic s);
        bus.sen = s;
        @(posedge clk);
        #1;
    endtask

    task automatic run_gesture(input int h1, input int l1, input int h2, input int tail,
                               output int ns, output int nl, output int nd, output int nr,
                               output int ev_first, output int ev_last, output int rep_first,
                               output int overlap);
        ns = 0; nl = 0; nd = 0; nr = 0;
        ev_first = -1; ev_last = -1; rep_first = -1; overlap = 0;
        for (int j = 0; j < h1 + l1 + h2 + tail; j++) begin
            step((j < h1) || (j >= h1 + l1 && j < h1 + l1 + h2));
            if (bus.short_press)  ns++;
            if (bus.long_press)   nl++;
            if (bus.double_press) nd++;
            if (bus.short_press | bus.long_press | bus.double_press) begin
                if (ev_first < 0) ev_first = j;
                ev_last = j;
            end
            if (int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press) > 1) overlap++;
            if (bus.repeat_pulse) begin
                nr++;
                if (rep_first < 0) rep_first = j;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int ns, nl, nd, nr, evf, evl, repf, ovl, pulses;
        int lead, npairs, total, pos, i, t0, r, cum;
        int his[$];
        int los[$];
        int ev[];
        bit wave[];
        logic [12:0] got, exp;

        vecs[0] = '{"short",        3, 0, 0,  0, 7,  0, -1};
        vecs[1] = '{"long_repeat", 20, 0, 0,  1, 8,  3, 11};
        vecs[2] = '{"double",       2, 2, 2,  2, 6,  0, -1};
        vecs[3] = '{"gap_edge_dbl", 2, 4, 2,  2, 8,  0, -1};
        vecs[4] = '{"hold8_short",  8, 0, 0,  0, 12, 0, -1};
        vecs[5] = '{"hold9_long",   9, 0, 0,  1, 8,  0, -1};
        vecs[6] = '{"hold11_long", 11, 0, 0,  1, 8,  0, -1};
        vecs[7] = '{"hold12_long", 12, 0, 0,  1, 8,  1, 11};
        vecs[8] = '{"dbl_long_2nd", 2, 1, 15, 2, 18, 0, -1};

        // Power-up reset with the button already held.
        reset   = 1'b1;
        bus.sen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.short_press, bus.long_press, bus.double_press,
                            bus.repeat_pulse, bus.pressed, bus.event_count}, 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1);
            if (bus.short_press | bus.long_press | bus.double_press | bus.repeat_pulse) pulses++;
        end
        chk("held_through_reset_pulses", pulses, 0);
        chk("held_pressed", bus.pressed, 1);
        chk("held_count", bus.event_count, 0);
        step(1'b0);
        step(1'b0);
        run_gesture(3, 0, 0, 10, ns, nl, nd, nr, evf, evl, repf, ovl);
        exp_cnt = 1;
        chk("after_reset_short", ns, 1);
        chk("after_reset_edge", evf, 7);
        chk("after_reset_count", bus.event_count, exp_cnt);

        // Table of single gestures.
        for (int v = 0; v < 9; v++) begin
            run_gesture(vecs[v].h1, vecs[v].l1, vecs[v].h2, 10, ns, nl, nd, nr, evf, evl, repf, ovl);
            exp_cnt = (exp_cnt + 1) % 256;
            chk({vecs[v].name, "_short"},  ns,  (vecs[v].kind == 0) ? 1 : 0);
            chk({vecs[v].name, "_long"},   nl,  (vecs[v].kind == 1) ? 1 : 0);
            chk({vecs[v].name, "_double"}, nd,  (vecs[v].kind == 2) ? 1 : 0);
            chk({vecs[v].name, "_edge"},   evf, vecs[v].ev_edge);
            chk({vecs[v].name, "_nrep"},   nr,  vecs[v].n_rep);
            chk({vecs[v].name, "_rep1"},   repf, vecs[v].rep_first);
            chk({vecs[v].name, "_ovl"},    ovl, 0);
            chk({vecs[v].name, "_count"},  bus.event_count, exp_cnt);
        end

        // Rise one edge after the gap timeout: short, then a fresh press.
        run_gesture(2, 5, 2, 10, ns, nl, nd, nr, evf, evl, repf, ovl);
        exp_cnt = (exp_cnt + 2) % 256;
        chk("gap_late_short_n", ns, 2);
        chk("gap_late_double_n", nd, 0);
        chk("gap_late_first", evf, 6);
        chk("gap_late_second", evl, 13);
        chk("gap_late_count", bus.event_count, exp_cnt);

        // Asynchronous reset in the middle of PRESS1.
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_clear", {bus.short_press, bus.long_press, bus.double_press,
                                  bus.repeat_pulse, bus.pressed, bus.event_count}, 32'd0);
        bus.sen = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 0;
        pulses  = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0);
            if (bus.short_press | bus.long_press | bus.double_press | bus.repeat_pulse) pulses++;
        end
        chk("aborted_no_pulse", pulses, 0);
        chk("aborted_count", bus.event_count, 0);

        // 256 short presses wrap the event counter.
        for (int w = 0; w < 256; w++) begin
            run_gesture(1, 0, 0, 6, ns, nl, nd, nr, evf, evl, repf, ovl);
            exp_cnt = (exp_cnt + 1) % 256;
            chk($sformatf("wrap_%0d", w + 1), bus.event_count, exp_cnt);
        end

        // Random waveform as alternating high/low runs, decoded gesture by gesture.
        lead   = 3;
        npairs = 40;
        for (int g = 0; g < npairs; g++) begin
            his.push_back(int'($urandom_range(12, 1)));
            los.push_back(int'($urandom_range(7, 1)));
        end
        los[npairs-1] = GAP + 2;
        total = lead;
        for (int g = 0; g < npairs; g++) total += his[g] + los[g];
        ev   = new[total];
        wave = new[total];
        for (int k = 0; k < total; k++) begin
            ev[k]   = 0;
            wave[k] = 1'b0;
        end
        pos = lead;
        for (int g = 0; g < npairs; g++) begin
            for (int k = 0; k < his[g]; k++) wave[pos + k] = 1'b1;
            pos += his[g] + los[g];
        end
        pos = lead;
        i   = 0;
        while (i < npairs) begin
            t0 = pos;
            if (his[i] >= LONG + 1) begin
                ev[t0 + LONG] |= 2;
                for (int e = t0 + LONG + REP; e <= t0 + his[i] - 1; e += REP) ev[e] |= 8;
                pos = t0 + his[i] + los[i];
                i   = i + 1;
            end else begin
                r = t0 + his[i];
                if (los[i] >= GAP + 1) begin
                    ev[r + GAP] |= 1;
                    pos = r + los[i];
                    i   = i + 1;
                end else begin
                    ev[r + los[i] + his[i+1]] |= 4;
                    pos = r + los[i] + his[i+1] + los[i+1];
                    i   = i + 2;
                end
            end
        end
        cum = exp_cnt;
        for (int k = 0; k < total; k++) begin
            step(wave[k]);
            if (ev[k] & 7) cum = (cum + 1) % 256;
            exp = {ev[k][0], ev[k][1], ev[k][2], ev[k][3], wave[k], cum[7:0]};
            got = {bus.short_press, bus.long_press, bus.double_press,
                   bus.repeat_pulse, bus.pressed, bus.event_count};
            chk($sformatf("rand_%0d", k), {19'd0, got}, {19'd0, exp});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
